// File: rtl/dpd_poly_engine_pkg.sv
// Shared types, sizing and fixed-point helpers for the DPD polynomial engine.
package dpd_poly_engine_pkg;

  localparam int DPD_CNT_LEN = 1024;
  localparam int DPD_CNT_W   = $clog2(DPD_CNT_LEN) + 1;

  typedef struct packed {
    logic                 start;
    logic [DPD_CNT_W-1:0] len;
    logic [4:0]           shift;
  } ctrl_dpd_t;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [DPD_CNT_W-1:0] cnt;
  } flags_dpd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } dpd_state_e;

  // Arithmetic right shift with round-half-up; sh is always >= 15 here.
  function automatic logic signed [47:0] rshift_round(input logic signed [47:0] val,
                                                      input logic [5:0] sh);
    logic signed [47:0] bias;
    bias = 48'sd1 <<< (sh - 6'd1);
    return (val + bias) >>> sh;
  endfunction

  function automatic logic [15:0] sat16(input logic signed [47:0] val);
    logic [15:0] res;
    if (val > 48'sd32767) begin
      res = 16'h7FFF;
    end else if (val < -48'sd32768) begin
      res = 16'h8000;
    end else begin
      res = val[15:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpd_poly_engine_cmul.sv
// Final pipeline stage: complex gain times sample, rounded, shifted and saturated
// to Q1.15, held in an enable-gated output register.
module dpd_poly_engine_cmul
  import dpd_poly_engine_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               en,
  input  logic signed [21:0] gr,
  input  logic signed [21:0] gi,
  input  logic signed [15:0] xr,
  input  logic signed [15:0] xi,
  input  logic        [4:0]  shift,
  output logic        [31:0] y
);

  logic signed [37:0] p_rr_s;
  logic signed [37:0] p_ii_s;
  logic signed [37:0] p_ri_s;
  logic signed [37:0] p_ir_s;
  logic signed [47:0] re_s;
  logic signed [47:0] im_s;
  logic        [5:0]  sh_s;
  logic        [31:0] y_r;

  assign p_rr_s = 38'(gr) * 38'(xr);
  assign p_ii_s = 38'(gi) * 38'(xi);
  assign p_ri_s = 38'(gr) * 38'(xi);
  assign p_ir_s = 38'(gi) * 38'(xr);
  assign sh_s   = 6'd15 + {1'b0, shift};
  assign re_s   = rshift_round(48'(p_rr_s) - 48'(p_ii_s), sh_s);
  assign im_s   = rshift_round(48'(p_ri_s) + 48'(p_ir_s), sh_s);

  // Result register; holds its value while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      y_r <= 32'd0;
    end else if (en) begin
      y_r <= {sat16(im_s), sat16(re_s)};
    end
  end

  assign y = y_r;

endmodule

// File: rtl/dpd_poly_engine.sv
// Memoryless odd-order DPD engine: y = x*(a1 + a3|x|^2 + a5|x|^4) over a
// 4-stage stallable stream pipeline with job control and a done pulse.
module dpd_poly_engine
  import dpd_poly_engine_pkg::*;
#(
  parameter int PIPE_STAGES = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic signed [15:0] a10_r,
  input  logic signed [15:0] a10_i,
  input  logic signed [15:0] a30_r,
  input  logic signed [15:0] a30_i,
  input  logic signed [15:0] a50_r,
  input  logic signed [15:0] a50_i,
  input  ctrl_dpd_t          ctrl_i,
  output flags_dpd_t         flags_o,
  input  logic        [31:0] x_data_i,
  input  logic               x_valid_i,
  output logic               x_ready_o,
  output logic        [31:0] y_data_o,
  output logic               y_valid_o,
  input  logic               y_ready_i
);

  dpd_state_e state_r;
  logic [DPD_CNT_W-1:0] len_r;
  logic [DPD_CNT_W-1:0] in_cnt_r;
  logic [DPD_CNT_W-1:0] out_cnt_r;
  logic [4:0]           shift_r;
  logic                 done_r;
  logic signed [15:0]   c10r_r, c10i_r, c30r_r, c30i_r, c50r_r, c50i_r;
  logic [PIPE_STAGES-1:0] v_r;

  logic [31:0]        s1_x_r;
  logic [31:0]        s1_rr_r;
  logic [31:0]        s1_ii_r;
  logic [31:0]        s2_x_r;
  logic [16:0]        s2_p2_r;
  logic [33:0]        s2_p2sq_r;
  logic [31:0]        s3_x_r;
  logic signed [21:0] s3_gr_r;
  logic signed [21:0] s3_gi_r;

  logic               en_s;
  logic               x_hs_s;
  logic               y_hs_s;
  logic signed [15:0] xr_s, xi_s;
  logic [31:0]        rr_s, ii_s;
  logic [32:0]        sum_s;
  logic [16:0]        p2_s;
  logic [33:0]        p2sq_s;
  logic [18:0]        p4_s;
  logic signed [17:0] p2_sgn_s;
  logic signed [19:0] p4_sgn_s;
  logic signed [33:0] m3r_s, m3i_s;
  logic signed [35:0] m5r_s, m5i_s;
  logic signed [21:0] gr_s, gi_s;

  assign en_s      = ~v_r[PIPE_STAGES-1] | y_ready_i;
  assign x_ready_o = en_s & (state_r == ST_RUN) & (in_cnt_r < len_r);
  assign x_hs_s    = x_valid_i & x_ready_o;
  assign y_hs_s    = v_r[PIPE_STAGES-1] & y_ready_i;

  // S1 operands: power of the incoming sample
  assign xr_s = x_data_i[15:0];
  assign xi_s = x_data_i[31:16];
  assign rr_s = 32'(32'(xr_s) * 32'(xr_s));
  assign ii_s = 32'(32'(xi_s) * 32'(xi_s));

  // S2: |x|^2 in Q1.15 (non-negative, so unsigned math is exact) and its square
  assign sum_s  = {1'b0, s1_rr_r} + {1'b0, s1_ii_r};
  assign p2_s   = 17'(({1'b0, sum_s} + 34'd16384) >> 15);
  assign p2sq_s = {17'd0, p2_s} * {17'd0, p2_s};

  // S3: |x|^4 and the complex polynomial gain, wrapping at 22 bits
  assign p4_s     = 19'(({1'b0, s2_p2sq_r} + 35'd16384) >> 15);
  assign p2_sgn_s = {1'b0, s2_p2_r};
  assign p4_sgn_s = {1'b0, p4_s};
  assign m3r_s    = 34'(c30r_r) * 34'(p2_sgn_s);
  assign m3i_s    = 34'(c30i_r) * 34'(p2_sgn_s);
  assign m5r_s    = 36'(c50r_r) * 36'(p4_sgn_s);
  assign m5i_s    = 36'(c50i_r) * 36'(p4_sgn_s);
  assign gr_s = 22'(48'(c10r_r) + rshift_round(48'(m3r_s), 6'd15)
                                + rshift_round(48'(m5r_s), 6'd15));
  assign gi_s = 22'(48'(c10i_r) + rshift_round(48'(m3i_s), 6'd15)
                                + rshift_round(48'(m5i_s), 6'd15));

  // Job FSM, counters, coefficient latch and done pulse
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_r   <= ST_IDLE;
      len_r     <= '0;
      shift_r   <= 5'd0;
      in_cnt_r  <= '0;
      out_cnt_r <= '0;
      done_r    <= 1'b0;
      c10r_r    <= 16'sd0;
      c10i_r    <= 16'sd0;
      c30r_r    <= 16'sd0;
      c30i_r    <= 16'sd0;
      c50r_r    <= 16'sd0;
      c50i_r    <= 16'sd0;
    end else begin
      done_r <= 1'b0;
      if (x_hs_s) begin
        in_cnt_r <= in_cnt_r + DPD_CNT_W'(1);
      end
      if (y_hs_s) begin
        out_cnt_r <= out_cnt_r + DPD_CNT_W'(1);
      end
      case (state_r)
        ST_IDLE: begin
          if (ctrl_i.start && (ctrl_i.len != '0)) begin
            state_r   <= ST_RUN;
            len_r     <= ctrl_i.len;
            shift_r   <= ctrl_i.shift;
            in_cnt_r  <= '0;
            out_cnt_r <= '0;
            c10r_r    <= a10_r;
            c10i_r    <= a10_i;
            c30r_r    <= a30_r;
            c30i_r    <= a30_i;
            c50r_r    <= a50_r;
            c50i_r    <= a50_i;
          end
        end
        ST_RUN: begin
          if (x_hs_s && ((in_cnt_r + DPD_CNT_W'(1)) == len_r)) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (y_hs_s && ((out_cnt_r + DPD_CNT_W'(1)) == len_r)) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // S1..S3 data registers and the valid chain, all gated by the common enable
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      v_r       <= '0;
      s1_x_r    <= 32'd0;
      s1_rr_r   <= 32'd0;
      s1_ii_r   <= 32'd0;
      s2_x_r    <= 32'd0;
      s2_p2_r   <= 17'd0;
      s2_p2sq_r <= 34'd0;
      s3_x_r    <= 32'd0;
      s3_gr_r   <= 22'sd0;
      s3_gi_r   <= 22'sd0;
    end else if (en_s) begin
      v_r       <= {v_r[PIPE_STAGES-2:0], x_hs_s};
      s1_x_r    <= x_data_i;
      s1_rr_r   <= rr_s;
      s1_ii_r   <= ii_s;
      s2_x_r    <= s1_x_r;
      s2_p2_r   <= p2_s;
      s2_p2sq_r <= p2sq_s;
      s3_x_r    <= s2_x_r;
      s3_gr_r   <= gr_s;
      s3_gi_r   <= gi_s;
    end
  end

  dpd_poly_engine_cmul u_cmul (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clear (clear_i),
    .en    (en_s),
    .gr    (s3_gr_r),
    .gi    (s3_gi_r),
    .xr    (s3_x_r[15:0]),
    .xi    (s3_x_r[31:16]),
    .shift (shift_r),
    .y     (y_data_o)
  );

  assign y_valid_o = v_r[PIPE_STAGES-1];
  assign flags_o   = '{busy: (state_r != ST_IDLE), done: done_r, cnt: out_cnt_r};

endmodule

// File: tb/tb_dpd_poly_engine.sv
// Directed, table-driven bench for dpd_poly_engine with hand-computed results
// plus sequences for backpressure, coefficient isolation, clear and reset.
module tb_dpd_poly_engine;
  import dpd_poly_engine_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni, clear_i;
  logic [15:0] a10_r, a10_i, a30_r, a30_i, a50_r, a50_i;
  ctrl_dpd_t   ctrl_i;
  flags_dpd_t  flags_o;
  logic [31:0] x_data_i, y_data_o;
  logic        x_valid_i, x_ready_o, y_valid_o, y_ready_i;

  int errors = 0;
  int checks = 0;

  logic [31:0] xin  [16];
  logic [31:0] yexp [16];

  typedef struct {
    string       name;
    logic [15:0] c10r, c10i, c30r, c30i, c50r, c50i;
    logic [4:0]  sh;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;
  vec_t vt [8];

  always #5 clk_i = ~clk_i;

  dpd_poly_engine dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .a10_r(a10_r), .a10_i(a10_i), .a30_r(a30_r), .a30_i(a30_i),
    .a50_r(a50_r), .a50_i(a50_i),
    .ctrl_i(ctrl_i), .flags_o(flags_o),
    .x_data_i(x_data_i), .x_valid_i(x_valid_i), .x_ready_o(x_ready_o),
    .y_data_o(y_data_o), .y_valid_o(y_valid_o), .y_ready_i(y_ready_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_coef(input logic [15:0] c10r, c10i, c30r, c30i, c50r, c50i);
    a10_r = c10r; a10_i = c10i; a30_r = c30r; a30_i = c30i; a50_r = c50r; a50_i = c50i;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " x_ready"}, {31'd0, x_ready_o}, 32'd0);
    chk({tag, " y_valid"}, {31'd0, y_valid_o}, 32'd0);
    chk({tag, " y_data"},  y_data_o, 32'd0);
    chk({tag, " busy"},    {31'd0, flags_o.busy}, 32'd0);
    chk({tag, " done"},    {31'd0, flags_o.done}, 32'd0);
    chk({tag, " cnt"},     32'(flags_o.cnt), 32'd0);
  endtask

  // Called just after a falling edge. Runs one job of n samples from xin and
  // checks each output against yexp.
  task automatic run_job(input string tag, input int n, input logic [4:0] sh,
                         input bit bp, input bit chg);
    int in_i, out_i, cyc;
    int hs_cyc [16];
    bit prev_stall, fin;
    logic [31:0] prev_d;
    in_i = 0; out_i = 0; cyc = 0; prev_stall = 1'b0; fin = 1'b0; prev_d = 32'd0;
    ctrl_i = '{start: 1'b1, len: DPD_CNT_W'(n), shift: sh};
    @(negedge clk_i);
    ctrl_i.start = 1'b0;
    while (!fin && cyc < 300) begin
      x_valid_i = (in_i < n);
      x_data_i  = (in_i < n) ? xin[in_i] : 32'd0;
      y_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (chg && cyc == 3) begin
        a10_r  = 16'h1000;
        ctrl_i = '{start: 1'b1, len: DPD_CNT_W'(2), shift: 5'd3};
      end else begin
        ctrl_i.start = 1'b0;
      end
      #1;
      if (prev_stall) chk({tag, " stable"}, y_data_o, prev_d);
      if (y_valid_o && !y_ready_i) chk({tag, " stall_xready"}, {31'd0, x_ready_o}, 32'd0);
      if (y_valid_o && y_ready_i) begin
        if (out_i < n) begin
          chk({tag, " y"}, y_data_o, yexp[out_i]);
          if (!bp) chk({tag, " latency"}, 32'(cyc - hs_cyc[out_i]), 32'd4);
        end else begin
          chk({tag, " extra_out"}, 32'(out_i), 32'(n - 1));
        end
        out_i++;
      end
      if (x_valid_i && x_ready_o) begin
        hs_cyc[in_i] = cyc;
        in_i++;
      end
      if (flags_o.done) begin
        chk({tag, " cnt_at_done"}, 32'(flags_o.cnt), 32'(n));
        fin = 1'b1;
      end
      prev_stall = y_valid_o && !y_ready_i;
      prev_d     = y_data_o;
      @(negedge clk_i);
      cyc++;
    end
    if (!fin) chk({tag, " done_timeout"}, 32'd0, 32'd1);
    chk({tag, " n_out"}, 32'(out_i), 32'(n));
    x_valid_i = 1'b0;
    y_ready_i = 1'b1;
    #1;
    chk({tag, " done_pulse"}, {31'd0, flags_o.done}, 32'd0);
    chk({tag, " busy_end"}, {31'd0, flags_o.busy}, 32'd0);
  endtask

  initial begin
    int n_hs, cyc, dcount;
    rst_ni = 1'b0; clear_i = 1'b0;
    set_coef(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    ctrl_i = '0; x_valid_i = 1'b0; x_data_i = 32'd0; y_ready_i = 1'b1;

    vt[0] = '{"linear",  16'h4000, 16'h0, 16'h0,    16'h0, 16'h0,    16'h0, 5'd0, 32'h0000_4000, 32'h0000_2000};
    vt[1] = '{"cubic",   16'h4000, 16'h0, 16'h4000, 16'h0, 16'h0,    16'h0, 5'd0, 32'h0000_4000, 32'h0000_2800};
    vt[2] = '{"sat_pos", 16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h0,    16'h0, 5'd0, 32'h7FFF_7FFF, 32'h7FFF_7FFF};
    vt[3] = '{"sat_neg", 16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h0,    16'h0, 5'd0, 32'h8001_8001, 32'h8000_8000};
    vt[4] = '{"quintic", 16'h0,    16'h0, 16'h0,    16'h0, 16'h4000, 16'h0, 5'd0, 32'h0000_4000, 32'h0000_0200};
    vt[5] = '{"imag_a1", 16'h0, 16'h4000, 16'h0,    16'h0, 16'h0,    16'h0, 5'd0, 32'h0000_4000, 32'h2000_0000};
    vt[6] = '{"shift1",  16'h4000, 16'h0, 16'h0,    16'h0, 16'h0,    16'h0, 5'd1, 32'h0000_4000, 32'h0000_1000};
    vt[7] = '{"round",   16'h4000, 16'h0, 16'h0,    16'h0, 16'h0,    16'h0, 5'd0, 32'hFFFF_0001, 32'h0000_0001};

    repeat (2) @(negedge clk_i);
    #1;
    chk_reset_vals("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 8; i++) begin
      set_coef(vt[i].c10r, vt[i].c10i, vt[i].c30r, vt[i].c30i, vt[i].c50r, vt[i].c50i);
      xin[0]  = vt[i].x;
      yexp[0] = vt[i].y;
      run_job(vt[i].name, 1, vt[i].sh, 1'b0, 1'b0);
    end

    // a1 = 0.5 only: y = x/2 exactly for multiples of 256
    for (int k = 0; k < 16; k++) begin
      xin[k]  = {16'(-(k + 1) * 256), 16'((k + 1) * 256)};
      yexp[k] = {16'(-(k + 1) * 128), 16'((k + 1) * 128)};
    end
    set_coef(16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    run_job("backpressure", 16, 5'd0, 1'b1, 1'b0);

    set_coef(16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    run_job("coef_iso", 6, 5'd0, 1'b0, 1'b1);

    // clear and start in the same cycle: clear wins
    set_coef(16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk_i);
    clear_i = 1'b1;
    ctrl_i  = '{start: 1'b1, len: DPD_CNT_W'(4), shift: 5'd0};
    @(negedge clk_i);
    clear_i = 1'b0;
    ctrl_i.start = 1'b0;
    #1;
    chk("clear_start busy", {31'd0, flags_o.busy}, 32'd0);
    chk("clear_start x_ready", {31'd0, x_ready_o}, 32'd0);

    // reset after 5 of 10 samples
    @(negedge clk_i);
    ctrl_i = '{start: 1'b1, len: DPD_CNT_W'(10), shift: 5'd0};
    @(negedge clk_i);
    ctrl_i.start = 1'b0;
    n_hs = 0;
    cyc  = 0;
    while (n_hs < 5 && cyc < 50) begin
      x_valid_i = 1'b1;
      x_data_i  = xin[n_hs];
      #1;
      if (x_ready_o) n_hs++;
      @(negedge clk_i);
      cyc++;
    end
    chk("rst_mid feed", 32'(n_hs), 32'd5);
    x_valid_i = 1'b0;
    rst_ni    = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    dcount = 0;
    repeat (10) begin
      @(negedge clk_i);
      #1;
      if (flags_o.done || y_valid_o) dcount++;
    end
    chk("rst_mid no_done_no_out", 32'(dcount), 32'd0);
    @(negedge clk_i);
    run_job("after_rst", 3, 5'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
